// File: rtl/jk_toggle_monitor.sv
// jk_toggle_monitor: checks a JK flip-flop's q/qbar against its characteristic equation and counts edges/errors
module jk_toggle_monitor #(
  parameter int CNT_W     = 8,
  parameter int STUCK_LIM = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  input  logic             qbar,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             mismatch,
  output logic             compl_err,
  output logic             stuck_err,
  output logic             active
);
  typedef enum logic [1:0] {IDLE, ARM, CHECK} state_t;
  state_t           state_q, state_d;
  logic             jd_q, kd_q, qd_q;
  logic [3:0]       stk_q, stk_d;
  logic [CNT_W-1:0] rise_q, rise_d, fall_q, fall_d, err_q, err_d;
  logic             mis_q, mis_d, cmp_q, cmp_d, stuck_q, stuck_d, active_q, active_d;
  logic             chk, exp_q, bad;
  always_comb begin
    chk      = state_q == CHECK;
    exp_q    = (jd_q & ~qd_q) | (~kd_q & qd_q);
    bad      = chk && (q != exp_q);
    state_d  = state_q == IDLE ? ARM : CHECK;
    rise_d   = rise_q + CNT_W'(chk & ~qd_q & q);
    fall_d   = fall_q + CNT_W'(chk & qd_q & ~q);
    err_d    = err_q + CNT_W'(bad && (err_q != '1));
    mis_d    = mis_q | bad;
    cmp_d    = cmp_q | (chk && (q == qbar));
    stk_d    = (chk && jd_q && kd_q && (q == qd_q)) ? stk_q + 4'(stk_q != 4'hf) : 4'd0;
    stuck_d  = stuck_q | (chk && (stk_d == 4'(STUCK_LIM)));
    active_d = state_d == CHECK;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      {jd_q, kd_q, qd_q} <= '0;
      stk_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      err_q    <= '0;
      {mis_q, cmp_q, stuck_q, active_q} <= '0;
    end else begin
      state_q  <= state_d;
      {jd_q, kd_q, qd_q} <= {j, k, q};
      stk_q    <= stk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      err_q    <= err_d;
      {mis_q, cmp_q, stuck_q, active_q} <= {mis_d, cmp_d, stuck_d, active_d};
    end
  end
  assign rise_cnt  = rise_q;
  assign fall_cnt  = fall_q;
  assign err_cnt   = err_q;
  assign mismatch  = mis_q;
  assign compl_err = cmp_q;
  assign stuck_err = stuck_q;
  assign active    = active_q;
endmodule

// File: tb/tb_jk_toggle_monitor.sv
// tb_jk_toggle_monitor: table vectors plus model-driven corner sequences, scoreboarded per clock
module tb_jk_toggle_monitor;
  localparam int CNT_W = 8;
  localparam int LIM   = 4;
  logic clk = 0, reset, j, k, q, qbar;
  logic [CNT_W-1:0] rise_cnt, fall_cnt, err_cnt;
  logic mismatch, compl_err, stuck_err, active;
  jk_toggle_monitor #(.CNT_W(CNT_W), .STUCK_LIM(LIM)) dut (
    .clk(clk), .reset(reset), .j(j), .k(k), .q(q), .qbar(qbar),
    .rise_cnt(rise_cnt), .fall_cnt(fall_cnt), .err_cnt(err_cnt),
    .mismatch(mismatch), .compl_err(compl_err), .stuck_err(stuck_err), .active(active)
  );
  always #5 clk = ~clk;
  typedef struct {logic a, mis, cmp, stk; int rise, fall, err;} exp_t;
  typedef struct {logic r, j, k, q, qb; exp_t e;} vec_t;
  exp_t sb[$];
  vec_t tbl[23];
  int n_chk = 0, n_fail = 0;
  int m_st = 0, m_stk = 0, m_rise = 0, m_fall = 0, m_err = 0;
  logic m_jd = 0, m_kd = 0, m_qd = 0, m_mis = 0, m_cmp = 0, m_stuck = 0, m_act = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  // reference behaviour of the monitor, advanced once per clock edge
  task automatic model(input logic r, jj, kk, qq, qb);
    logic e;
    if (r) begin
      m_st = 0; m_stk = 0; m_rise = 0; m_fall = 0; m_err = 0;
      {m_jd, m_kd, m_qd, m_mis, m_cmp, m_stuck} = '0;
    end else begin
      if (m_st == 2) begin
        e = (m_jd && !m_qd) || (!m_kd && m_qd);
        if (qq !== e) begin
          m_mis = 1;
          if (m_err < (1 << CNT_W) - 1) m_err++;
        end
        if (qq === qb) m_cmp = 1;
        if (!m_qd && qq) m_rise = (m_rise + 1) % (1 << CNT_W);
        if (m_qd && !qq) m_fall = (m_fall + 1) % (1 << CNT_W);
        if (m_jd && m_kd && qq == m_qd) m_stk = (m_stk < 15) ? m_stk + 1 : 15;
        else m_stk = 0;
        if (m_stk == LIM) m_stuck = 1;
      end else m_stk = 0;
      m_st = (m_st == 0) ? 1 : 2;
      m_jd = jj; m_kd = kk; m_qd = qq;
    end
    m_act = (m_st == 2);
  endtask
  function automatic exp_t mexp();
    exp_t e;
    e.a = m_act; e.mis = m_mis; e.cmp = m_cmp; e.stk = m_stuck;
    e.rise = m_rise; e.fall = m_fall; e.err = m_err;
    return e;
  endfunction
  task automatic step(input logic r, jj, kk, qq, qb, input exp_t e);
    exp_t x;
    reset = r; j = jj; k = kk; q = qq; qbar = qb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("active", active, x.a);
    chk("mismatch", mismatch, x.mis);
    chk("compl_err", compl_err, x.cmp);
    chk("stuck_err", stuck_err, x.stk);
    chk("rise_cnt", rise_cnt, x.rise);
    chk("fall_cnt", fall_cnt, x.fall);
    chk("err_cnt", err_cnt, x.err);
  endtask
  task automatic drv(input logic r, jj, kk, qq, qb);
    model(r, jj, kk, qq, qb);
    step(r, jj, kk, qq, qb, mexp());
  endtask
  initial begin
    //          r  j  k  q qb    a mis cmp stk rise fall err
    tbl[0]  = '{1, 0, 1, 0, 1, '{0, 0, 0, 0, 0, 0, 0}};
    tbl[1]  = '{1, 0, 1, 0, 1, '{0, 0, 0, 0, 0, 0, 0}};
    tbl[2]  = '{0, 0, 1, 0, 1, '{0, 0, 0, 0, 0, 0, 0}};
    tbl[3]  = '{0, 0, 1, 0, 1, '{1, 0, 0, 0, 0, 0, 0}};
    tbl[4]  = '{0, 0, 1, 0, 1, '{1, 0, 0, 0, 0, 0, 0}};
    tbl[5]  = '{0, 1, 0, 0, 1, '{1, 0, 0, 0, 0, 0, 0}};
    tbl[6]  = '{0, 1, 1, 1, 0, '{1, 0, 0, 0, 1, 0, 0}};
    tbl[7]  = '{0, 1, 1, 0, 1, '{1, 0, 0, 0, 1, 1, 0}};
    tbl[8]  = '{0, 1, 1, 1, 0, '{1, 0, 0, 0, 2, 1, 0}};
    tbl[9]  = '{0, 1, 1, 0, 1, '{1, 0, 0, 0, 2, 2, 0}};
    tbl[10] = '{0, 0, 0, 1, 0, '{1, 0, 0, 0, 3, 2, 0}};
    tbl[11] = '{0, 0, 0, 1, 0, '{1, 0, 0, 0, 3, 2, 0}};
    tbl[12] = '{0, 0, 0, 1, 1, '{1, 0, 1, 0, 3, 2, 0}};
    tbl[13] = '{0, 0, 0, 1, 0, '{1, 0, 1, 0, 3, 2, 0}};
    tbl[14] = '{0, 0, 1, 1, 0, '{1, 0, 1, 0, 3, 2, 0}};
    tbl[15] = '{0, 1, 0, 0, 1, '{1, 0, 1, 0, 3, 3, 0}};
    tbl[16] = '{0, 1, 0, 0, 1, '{1, 1, 1, 0, 3, 3, 1}};
    tbl[17] = '{0, 0, 1, 1, 0, '{1, 1, 1, 0, 4, 3, 1}};
    tbl[18] = '{0, 0, 1, 0, 1, '{1, 1, 1, 0, 4, 4, 1}};
    tbl[19] = '{1, 0, 1, 0, 1, '{0, 0, 0, 0, 0, 0, 0}};
    tbl[20] = '{0, 0, 1, 1, 1, '{0, 0, 0, 0, 0, 0, 0}};
    tbl[21] = '{0, 0, 1, 1, 1, '{1, 0, 0, 0, 0, 0, 0}};
    tbl[22] = '{0, 0, 1, 0, 1, '{1, 0, 0, 0, 0, 1, 0}};
    for (int i = 0; i < 23; i++) begin
      model(tbl[i].r, tbl[i].j, tbl[i].k, tbl[i].q, tbl[i].qb);
      step(tbl[i].r, tbl[i].j, tbl[i].k, tbl[i].q, tbl[i].qb, tbl[i].e);
    end
    // q held low while set is commanded: err_cnt must pin at all-ones
    for (int i = 0; i < 300; i++) drv(0, 1, 0, 0, 1);
    chk("err_cnt_saturated", err_cnt, 255);
    // ignored toggles: three, then a genuine toggle pair, then four in a row
    drv(1, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) drv(0, 0, 1, 0, 1);
    drv(0, 1, 0, 0, 1);
    drv(0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) drv(0, 1, 1, 1, 0);
    drv(0, 1, 1, 0, 1);
    drv(0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) drv(0, 1, 1, 1, 0);
    chk("stuck_after_3", stuck_err, 0);
    drv(0, 1, 1, 1, 0);
    chk("stuck_after_4", stuck_err, 1);
    drv(1, 1, 1, 1, 0);
    chk("reset_clears_stuck", stuck_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
